ro_calibration_controller: RTL and testbench

Sequencer for the ring-oscillator bank and its oscillator-select mux. On request it powers the bank, steps the mux through every oscillator, and measures each one's frequency by counting its rising edges over a fixed gate window of the 50 MHz reference clock. It then selects the oscillator whose count is closest to a programmed target and leaves the mux on it. It sits between the oscillator bank/mux and FrequencyRegulatorAndDivider, whose `clk` input is driven by the selected oscillator.

---
 rtl/ro_calibration_controller.sv | 144 ++++++++++++++
 tb/tb_ro_calibration_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ro_calibration_controller.sv
// Ring-oscillator bank calibration sequencer: measures each oscillator over a fixed
// gate window of clk_50M and parks the mux on the one closest to the target count.
module ro_calibration_controller #(
  parameter int NUM_RO        = 4,
  parameter int SEL_W         = 2,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target_count,
  input  logic             ro_clk,
  output logic             ro_on,
  output logic [SEL_W-1:0] choose,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SEL_W-1:0] best_sel,
  output logic [CNT_W-1:0] best_count
);

  localparam int TMAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TIM_W = $clog2(TMAX + 1);

  localparam logic [TIM_W-1:0] SETTLE_LAST = TIM_W'(SETTLE_CYCLES - 1);
  localparam logic [TIM_W-1:0] GATE_LAST   = TIM_W'(GATE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_RO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    COMPARE,
    FINISH
  } state_t;

  state_t           state;
  logic [2:0]       sync;
  logic             edge_seen;
  logic [TIM_W-1:0] timer;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] best_diff;
  logic [CNT_W-1:0] diff;

  // Two flops for metastability, the third remembers the previous level for edge detection.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], ro_clk};
    end
  end

  assign edge_seen = sync[1] & ~sync[2];

  // Absolute distance from target, ordered so the subtraction never wraps.
  assign diff = (count >= target) ? (count - target) : (target - count);

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      count      <= '0;
      target     <= '0;
      best_diff  <= '0;
      ro_on      <= 1'b0;
      choose     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      best_sel   <= '0;
      best_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target <= target_count;
            err    <= 1'b0;
            choose <= '0;
            ro_on  <= 1'b1;
            busy   <= 1'b1;
            timer  <= '0;
            count  <= '0;
            state  <= SETTLE;
          end
        end

        SETTLE: begin
          count <= '0;
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            state <= MEASURE;
          end else begin
            timer <= timer + TIM_W'(1);
          end
        end

        MEASURE: begin
          if (edge_seen && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
          end
          if (timer == GATE_LAST) begin
            timer <= '0;
            state <= COMPARE;
          end else begin
            timer <= timer + TIM_W'(1);
          end
        end

        COMPARE: begin
          // Strict less-than keeps the lowest index on ties; index 0 always seeds the best.
          if ((choose == '0) || (diff < best_diff)) begin
            best_sel   <= choose;
            best_count <= count;
            best_diff  <= diff;
          end
          if (choose == LAST_SEL) begin
            state <= FINISH;
          end else begin
            choose <= choose + SEL_W'(1);
            state  <= SETTLE;
          end
        end

        FINISH: begin
          choose <= best_sel;
          done   <= 1'b1;
          err    <= (best_count == '0);
          ro_on  <= (best_count != '0);
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_calibration_controller.sv
// Directed bench for ro_calibration_controller: behavioural oscillator bank and mux,
// a default 16-bit instance and an 8-bit instance used for counter saturation.
module tb_ro_calibration_controller;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sat_en = 1'b0;
  logic [15:0] target_count = '0;
  logic [7:0]  target_sat = '0;
  logic        dead = 1'b0;

  int half_main [4] = '{50, 40, 30, 25};
  int half_sat  [4] = '{50, 50, 50, 25};

  logic [3:0] osc_main;
  logic [3:0] osc_sat;
  logic       ro_main;
  logic       ro_sat;
  logic       start_sat;

  logic        ro_on, busy, done, err;
  logic [1:0]  choose, best_sel;
  logic [15:0] best_count;

  logic        ro_on_s, busy_s, done_s, err_s;
  logic [1:0]  choose_s, best_sel_s;
  logic [7:0]  best_count_s;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic busy_fin;

  always #10 clk_50M = ~clk_50M;

  // Oscillator toggle times stay at 3 mod 5, so they never coincide with a clk_50M edge.
  for (genvar g = 0; g < 4; g++) begin : g_osc
    logic om = 1'b0;
    logic os = 1'b0;
    initial begin
      #3;
      forever begin
        #(half_main[g]);
        om = ~om;
      end
    end
    initial begin
      #3;
      forever begin
        #(half_sat[g]);
        os = ~os;
      end
    end
    assign osc_main[g] = om;
    assign osc_sat[g]  = os;
  end

  assign ro_main   = dead ? 1'b0 : osc_main[choose];
  assign ro_sat    = osc_sat[choose_s];
  assign start_sat = start & sat_en;

  ro_calibration_controller dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .start        (start),
    .target_count (target_count),
    .ro_clk       (ro_main),
    .ro_on        (ro_on),
    .choose       (choose),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .best_sel     (best_sel),
    .best_count   (best_count)
  );

  ro_calibration_controller #(.CNT_W(8)) dut_sat (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .start        (start_sat),
    .target_count (target_sat),
    .ro_clk       (ro_sat),
    .ro_on        (ro_on_s),
    .choose       (choose_s),
    .busy         (busy_s),
    .done         (done_s),
    .err          (err_s),
    .best_sel     (best_sel_s),
    .best_count   (best_count_s)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    vectors++;
    assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Leaves the bench at the falling edge just after the accepting clock edge (k = 0).
  task automatic apply_stimulus(input logic [15:0] tgt);
    @(negedge clk_50M);
    target_count = tgt;
    start = 1'b1;
    @(posedge clk_50M);
    @(negedge clk_50M);
    start = 1'b0;
  endtask

  // Counts clock edges since the accepting edge until done is seen, with optional start
  // pulses at sample points pulse_a/pulse_b and start held high from hold_from onward.
  task automatic wait_done(input int pulse_a, input int pulse_b, input int hold_from,
                           output int k, output logic busy_finish);
    k = 0;
    busy_finish = 1'b0;
    forever begin
      start = (k == pulse_a) || (k == pulse_b) || ((hold_from >= 0) && (k >= hold_from));
      @(posedge clk_50M);
      k++;
      @(negedge clk_50M);
      if (done || k >= 5000) break;
      busy_finish = busy;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #4;
    check_output("rst_ro_on", ro_on, 0);
    check_output("rst_choose", choose, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_best_sel", best_sel, 0);
    check_output("rst_best_count", best_count, 0);
    @(negedge clk_50M);
    rst = 1'b1;
    repeat (2) @(negedge clk_50M);

    $display("[TB] selection run, periods 100/80/60/50, target 250 (with saturation instance)");
    sat_en = 1'b1;
    target_sat = 8'd255;
    apply_stimulus(16'd250);
    sat_en = 1'b0;
    check_output("sel_busy_k0", busy, 1);
    check_output("sat_busy_k0", busy_s, 1);
    wait_done(-1, -1, -1, lat, busy_fin);
    check_output("sel_done_latency", lat, 4069);
    check_output("sel_busy_in_finish", busy_fin, 1);
    check_output("sel_busy_after", busy, 0);
    check_output("sel_best_sel", best_sel, 1);
    check_range("sel_best_count", best_count, 249, 251);
    check_output("sel_choose", choose, 1);
    check_output("sel_ro_on", ro_on, 1);
    check_output("sel_err", err, 0);
    check_output("sat_done", done_s, 1);
    check_output("sat_best_sel", best_sel_s, 3);
    check_output("sat_best_count", best_count_s, 255);
    check_output("sat_choose", choose_s, 3);
    @(negedge clk_50M);
    check_output("sel_done_single", done, 0);

    $display("[TB] tie run, periods 100/80/80/50, target 250");
    half_main = '{50, 40, 40, 25};
    apply_stimulus(16'd250);
    wait_done(-1, -1, -1, lat, busy_fin);
    check_output("tie_done_latency", lat, 4069);
    check_output("tie_best_sel", best_sel, 1);
    check_output("tie_best_count", best_count, 250);
    check_output("tie_choose", choose, 1);

    $display("[TB] target 0 run");
    apply_stimulus(16'd0);
    wait_done(-1, -1, -1, lat, busy_fin);
    check_output("t0_best_sel", best_sel, 0);
    check_range("t0_best_count", best_count, 199, 201);
    check_output("t0_choose", choose, 0);

    $display("[TB] dead bank run");
    dead = 1'b1;
    apply_stimulus(16'd250);
    wait_done(-1, -1, -1, lat, busy_fin);
    check_output("dead_done_latency", lat, 4069);
    check_output("dead_err", err, 1);
    check_output("dead_ro_on", ro_on, 0);
    check_output("dead_best_count", best_count, 0);
    check_output("dead_best_sel", best_sel, 0);
    dead = 1'b0;
    half_main = '{50, 40, 30, 25};

    $display("[TB] reset during second measurement");
    apply_stimulus(16'd250);
    check_output("rerun_err_cleared", err, 0);
    check_output("rerun_busy", busy, 1);
    repeat (1100) @(negedge clk_50M);
    check_output("mid_choose_before", choose, 1);
    #3 rst = 1'b0;
    #1;
    check_output("mid_ro_on", ro_on, 0);
    check_output("mid_choose", choose, 0);
    check_output("mid_busy", busy, 0);
    check_output("mid_done", done, 0);
    check_output("mid_err", err, 0);
    check_output("mid_best_sel", best_sel, 0);
    check_output("mid_best_count", best_count, 0);
    repeat (2) @(negedge clk_50M);
    rst = 1'b1;
    repeat (3) @(negedge clk_50M);
    check_output("post_rst_busy", busy, 0);
    check_output("post_rst_ro_on", ro_on, 0);

    $display("[TB] start pulses while busy, then start held through FINISH");
    apply_stimulus(16'd250);
    wait_done(5, 500, 4060, lat, busy_fin);
    check_output("busy_run_latency", lat, 4069);
    check_output("busy_run_best_sel", best_sel, 1);
    @(posedge clk_50M);
    @(negedge clk_50M);
    check_output("held_restart_busy", busy, 1);
    check_output("held_restart_done", done, 0);
    wait_done(-1, -1, -1, lat, busy_fin);
    check_output("held_run_latency", lat, 4069);
    check_output("held_run_best_sel", best_sel, 1);
    check_output("held_run_ro_on", ro_on, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
